alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  the request fields are valid.
REQ-005 SHALL provide port in_ready  output  1  the block can accept a request.
REQ-006 SHALL provide port opcode  input  4  operation select.
REQ-007 SHALL provide port operand1  input  WIDTH  first operand, unsigned.
REQ-008 SHALL provide port operand2  input  WIDTH  second operand, unsigned.
REQ-009 SHALL provide port out_valid  output  1  result and flags are valid.
REQ-010 SHALL provide port out_ready  input  1  the consumer accepts the result.
REQ-011 SHALL provide port result  output  2*WIDTH  registered result.
REQ-012 SHALL provide ports flag_c, flag_z and flag_dz  output  1 each  carry/borrow, zero and divide-by-zero flags.

Function
REQ-013 SHALL use opcodes ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8; opcodes 9-15 are ILLEGAL.
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE; in_ready=1 only in IDLE with rst low; out_valid=1 only in DONE.
REQ-015 SHALL accept a request on a clock edge where in_valid && in_ready, capturing opcode and both operands; the inputs are ignored at all other times.
REQ-016 SHALL treat single-cycle ops (ADD, SUB, logic, ILLEGAL, DIV by zero) as follows: they go IDLE->DONE on the accept edge, and out_valid is high in the following cycle.
REQ-017 SHALL treat iterative ops (DIV with a nonzero divisor; MUL when iterative per REQ-029) as follows: they go IDLE->BUSY on the accept edge and perform one shift step per BUSY edge for exactly WIDTH steps. The last step moves the FSM to DONE, so out_valid rises WIDTH+1 edges after the accept edge.
REQ-018 SHALL hold result and all flags stable in DONE until out_ready=1. DONE->IDLE occurs on that edge, and there is no back-to-back accept in the same edge.
REQ-019 SHALL compute ADD as follows: result[WIDTH:0] = operand1+operand2 with upper bits 0, and flag_c = result[WIDTH].
REQ-020 SHALL compute SUB as follows: result[WIDTH-1:0] = (operand1-operand2) mod 2^WIDTH, result[WIDTH] = flag_c = borrow (operand1<operand2), and upper bits 0.
REQ-021 SHALL compute MUL as the full 2*WIDTH-bit unsigned product, with flag_c=0.
REQ-022 SHALL compute DIV with the quotient in result[WIDTH-1:0] and the remainder in result[2*WIDTH-1:WIDTH], using restoring division, with flag_c=0.
REQ-023 SHALL handle DIV with operand2=0 as follows: quotient all ones, remainder=operand1, flag_dz=1, single-cycle. flag_dz SHALL be 0 for every other case.
REQ-024 SHALL compute the logic ops WIDTH bits wide with upper WIDTH result bits 0 (NAND/NOR do not set upper bits) and flag_c=0.
REQ-025 SHALL return result=0 and flag_c=flag_dz=0 for ILLEGAL opcodes.
REQ-026 SHALL set flag_z = (full 2*WIDTH result == 0) for every opcode, including ILLEGAL.

Reset
REQ-027 SHALL, on a rising edge with rst=1, set the state to IDLE and set result, flag_c, flag_z, flag_dz, out_valid and the iteration counter to 0. in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.
REQ-028 SHALL let rst asserted in BUSY or DONE abandon the operation, so that no out_valid is produced for it; rst SHALL take priority over accept and out_ready on the same edge.

Configuration
REQ-029 SHALL support macro ALU_SEQ_FAST_MUL_EN, selecting the MUL implementation: when defined, MUL is a single-cycle op using a combinational WIDTH x WIDTH multiplier; when undefined, MUL is an iterative shift-add taking WIDTH BUSY steps per REQ-017. Results SHALL be bit-identical in both builds; only latency differs.

Verification (WIDTH=8 unless stated)
REQ-030 SHALL cover ADD 0xFF+0x01 -> result=0x0100, flag_c=1, flag_z=0, out_valid one cycle after accept.
REQ-031 SHALL cover SUB 0x05-0x05 -> result=0x0000, flag_z=1, flag_c=0; and SUB 0x03-0x05 -> result=0x01FE, flag_c=1.
REQ-032 SHALL cover DIV 200/7 -> result=0x041C (remainder 4, quotient 28), out_valid 9 edges after accept; and DIV 0x2A/0 -> result=0x2AFF, flag_dz=1, out_valid after 1 edge.
REQ-033 SHALL cover MUL 0xFF*0xFF -> result=0xFE01 with latency 1 (macro defined) or 9 (undefined); and with WIDTH=16, 0xFFFF*0xFFFF -> 0xFFFE0001.
REQ-034 SHALL cover the handshake: hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout; pulse in_valid during BUSY -> ignored.
REQ-035 SHALL cover reset in mid-DIV at step 4 -> out_valid never asserts for that op, with all outputs 0 and in_ready=1 the cycle after rst falls; and opcode 0xC -> result=0, flag_z=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a valid/ready
// result port. ADD/SUB/logic/ILLEGAL and divide-by-zero finish in one cycle;
// DIV (restoring) and, by default, MUL (shift-add) take WIDTH BUSY steps.
// Build option: define ALU_SEQ_FAST_MUL_EN to make MUL a single-cycle
// combinational multiply. Results are identical in both builds.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_dz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;

    localparam logic [WIDTH-1:0]   W_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   W_ONES  = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] R_ZERO  = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One restoring-division step. The partial remainder lives in the upper
    // half and the dividend/quotient shift register in the lower half: the
    // dividend MSB shifts into the remainder and a quotient bit shifts in at
    // the LSB. The remainder is always below the divisor, so WIDTH bits hold it.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] divisor
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (shifted >= {1'b0, divisor}) begin
            div_step = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        end
    endfunction

`ifndef ALU_SEQ_FAST_MUL_EN
    // One shift-add multiply step. The multiplier starts in the lower half;
    // each step conditionally adds the multiplicand into the upper half and
    // shifts the whole pair right, so after WIDTH steps the pair is the product.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] mcand
    );
        logic [WIDTH:0] sum;
        if (lo[0]) begin
            sum = {1'b0, hi} + {1'b0, mcand};
        end else begin
            sum = {1'b0, hi};
        end
        mul_step = {sum, lo[WIDTH-1:1]};
    endfunction
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 flag_c_q, flag_c_d;
    logic                 flag_z_q, flag_z_d;
    logic                 flag_dz_q, flag_dz_d;

    logic                 accept_s;
    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic [2*WIDTH-1:0]   sc_result_s;
    logic                 sc_c_s;
    logic                 sc_dz_s;
    logic                 sc_iter_s;
    logic                 sc_div_s;
    logic [2*WIDTH-1:0]   step_s;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign accept_s  = in_valid && in_ready;

    assign add_s = {1'b0, operand1} + {1'b0, operand2};
    assign sub_s = {1'b0, operand1} - {1'b0, operand2};

    assign result  = result_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign flag_dz = flag_dz_q;

    // Decode the incoming opcode: single-cycle result/flags, or which iterative op to start
    always_comb begin
        sc_result_s = R_ZERO;
        sc_c_s      = 1'b0;
        sc_dz_s     = 1'b0;
        sc_iter_s   = 1'b0;
        sc_div_s    = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_result_s = {{(WIDTH-1){1'b0}}, add_s};
                sc_c_s      = add_s[WIDTH];
            end
            OP_SUB: begin
                sc_result_s = {{(WIDTH-1){1'b0}}, sub_s};
                sc_c_s      = sub_s[WIDTH];
            end
            OP_MUL: begin
`ifdef ALU_SEQ_FAST_MUL_EN
                sc_result_s = {W_ZERO, operand1} * {W_ZERO, operand2};
`else
                sc_iter_s   = 1'b1;
`endif
            end
            OP_DIV: begin
                if (operand2 == W_ZERO) begin
                    sc_result_s = {operand1, W_ONES};
                    sc_dz_s     = 1'b1;
                end else begin
                    sc_iter_s   = 1'b1;
                    sc_div_s    = 1'b1;
                end
            end
            OP_AND:  sc_result_s = {W_ZERO, operand1 & operand2};
            OP_OR:   sc_result_s = {W_ZERO, operand1 | operand2};
            OP_NAND: sc_result_s = {W_ZERO, ~(operand1 & operand2)};
            OP_NOR:  sc_result_s = {W_ZERO, ~(operand1 | operand2)};
            OP_XOR:  sc_result_s = {W_ZERO, operand1 ^ operand2};
            default: sc_result_s = R_ZERO;
        endcase
    end

    // Next iteration value of the shared hi/lo shift pair for the active iterative op
    always_comb begin
        step_s = {hi_q, lo_q};
        if (is_div_q) begin
            step_s = div_step(hi_q, lo_q, opb_q);
        end else begin
`ifdef ALU_SEQ_FAST_MUL_EN
            step_s = {hi_q, lo_q};
`else
            step_s = mul_step(hi_q, lo_q, opb_q);
`endif
        end
    end

    // FSM next state and datapath next values; everything holds unless updated
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        flag_dz_d = flag_dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    cnt_d = CNT_ZERO;
                    if (sc_iter_s) begin
                        state_d  = S_BUSY;
                        is_div_d = sc_div_s;
                        hi_d     = W_ZERO;
                        if (sc_div_s) begin
                            lo_d  = operand1;
                            opb_d = operand2;
                        end else begin
                            lo_d  = operand2;
                            opb_d = operand1;
                        end
                    end else begin
                        state_d   = S_DONE;
                        result_d  = sc_result_s;
                        flag_c_d  = sc_c_s;
                        flag_dz_d = sc_dz_s;
                        flag_z_d  = (sc_result_s == R_ZERO);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                hi_d = step_s[2*WIDTH-1:WIDTH];
                lo_d = step_s[WIDTH-1:0];
                if (cnt_q == LAST_STEP) begin
                    state_d   = S_DONE;
                    cnt_d     = CNT_ZERO;
                    result_d  = step_s;
                    flag_c_d  = 1'b0;
                    flag_dz_d = 1'b0;
                    flag_z_d  = (step_s == R_ZERO);
                end else begin
                    state_d = S_BUSY;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                // Release only; a new request is not taken on this same edge
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over accept and out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            is_div_q  <= 1'b0;
            opb_q     <= W_ZERO;
            hi_q      <= W_ZERO;
            lo_q      <= W_ZERO;
            result_q  <= R_ZERO;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            flag_c_q  <= flag_c_d;
            flag_z_q  <= flag_z_d;
            flag_dz_q <= flag_dz_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against an
// arithmetic reference model, handshake behaviour, mid-operation reset and a
// 16-bit multiply on a second instance.
module tb_alu_seq;

    localparam int W = 8;
`ifdef ALU_SEQ_FAST_MUL_EN
    localparam int MUL_LAT   = 1;
    localparam int MUL_LAT16 = 1;
`else
    localparam int MUL_LAT   = W + 1;
    localparam int MUL_LAT16 = 17;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready, out_valid, out_ready;
    logic [3:0]      opcode;
    logic [W-1:0]    operand1, operand2;
    logic [2*W-1:0]  result;
    logic            flag_c, flag_z, flag_dz;

    logic            in_valid16, in_ready16, out_valid16, out_ready16;
    logic [3:0]      opcode16;
    logic [15:0]     operand1_16, operand2_16;
    logic [31:0]     result16;
    logic            flag_c16, flag_z16, flag_dz16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_dz(flag_dz)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .opcode(opcode16), .operand1(operand1_16), .operand2(operand2_16),
        .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
        .flag_c(flag_c16), .flag_z(flag_z16), .flag_dz(flag_dz16)
    );

    // Reference model: the arithmetic meaning of each opcode, plus latency in edges
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output logic [2:0] f, output int lat);
        int ia;
        int ib;
        int v;
        logic c;
        logic dz;
        ia = int'(a);
        ib = int'(b);
        v = 0;
        c = 1'b0;
        dz = 1'b0;
        lat = 1;
        case (op)
            4'd0: begin v = ia + ib; c = (ia + ib) > 255; end
            4'd1: begin v = ((ia - ib) & 255) + ((ia < ib) ? 256 : 0); c = (ia < ib); end
            4'd2: begin v = ia * ib; lat = MUL_LAT; end
            4'd3: begin
                if (ib == 0) begin v = ia * 256 + 255; dz = 1'b1; end
                else begin v = (ia % ib) * 256 + (ia / ib); lat = W + 1; end
            end
            4'd4: v = ia & ib;
            4'd5: v = ia | ib;
            4'd6: v = 255 - (ia & ib);
            4'd7: v = 255 - (ia | ib);
            4'd8: v = ia ^ ib;
            default: v = 0;
        endcase
        r = 16'(v);
        f = {c, (v == 0), dz};
    endfunction

    // Issue one request, wait (bounded) for the result, optionally stall, then consume
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold, output logic [15:0] r, output logic [2:0] f,
                         output int lat);
        @(negedge clk);
        opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        f = {flag_c, flag_z, flag_dz};
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
        end
        checks++;
        if (result !== 16'h0000 || {flag_c, flag_z, flag_dz} !== 3'b000) begin
            errors++; $display("FAIL reset_out: result=%h flags=%b, want 0000 000", result, {flag_c, flag_z, flag_dz});
        end
        checks++;
        if (result16 !== 32'h0 || out_valid16 !== 1'b0 || in_ready16 !== 1'b0) begin
            errors++; $display("FAIL reset16: result=%h ov=%b ir=%b, want 0 0 0", result16, out_valid16, in_ready16);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready16 !== 1'b1) begin
            errors++; $display("FAIL reset_release: in_ready=%b in_ready16=%b, want 1 1", in_ready, in_ready16);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[11];
        logic [15:0] r;
        logic [2:0]  f;
        int lat;
        vecs = '{
            '{4'd0, 8'hFF, 8'h01, 16'h0100, 3'b100, 1},
            '{4'd1, 8'h05, 8'h05, 16'h0000, 3'b010, 1},
            '{4'd1, 8'h03, 8'h05, 16'h01FE, 3'b100, 1},
            '{4'd3, 8'd200, 8'd7, 16'h041C, 3'b000, 9},
            '{4'd3, 8'h2A, 8'h00, 16'h2AFF, 3'b001, 1},
            '{4'd2, 8'hFF, 8'hFF, 16'hFE01, 3'b000, MUL_LAT},
            '{4'hC, 8'h5A, 8'h33, 16'h0000, 3'b010, 1},
            '{4'd6, 8'hF0, 8'hFF, 16'h000F, 3'b000, 1},
            '{4'd7, 8'h00, 8'h00, 16'h00FF, 3'b000, 1},
            '{4'd8, 8'hAA, 8'hAA, 16'h0000, 3'b010, 1},
            '{4'd3, 8'h05, 8'h09, 16'h0500, 3'b000, 9}
        };
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, f, lat);
            checks++;
            if (r !== vecs[i].r) begin
                errors++; $display("FAIL dir_result[%0d]: got %h want %h", i, r, vecs[i].r);
            end
            checks++;
            if (f !== vecs[i].f) begin
                errors++; $display("FAIL dir_flags[%0d]: got c/z/dz=%b want %b", i, f, vecs[i].f);
            end
            checks++;
            if (lat != vecs[i].lat) begin
                errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, vecs[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [7:0]  a, b;
        logic [15:0] r, er;
        logic [2:0]  f, ef;
        int lat, elat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            model(op, a, b, er, ef, elat);
            do_op(op, a, b, $urandom_range(0, 2), r, f, lat);
            checks++;
            if (r !== er || f !== ef || lat != elat) begin
                errors++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: got r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                         i, op, a, b, r, f, lat, er, ef, elat);
            end
        end
    endtask

    task automatic test_handshake();
        int n;
        // Stall a result for 5 cycles while spurious requests are presented
        @(negedge clk);
        opcode = 4'd0; operand1 = 8'h12; operand2 = 8'h34; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL hs_first: out_valid=%b want 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = 4'd1; operand1 = 8'h99; operand2 = 8'h11;
            @(posedge clk); #1;
            checks++;
            if (result !== 16'h0046 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hs_stall[%0d]: result=%h ov=%b ir=%b want 0046 1 0", i, result, out_valid, in_ready);
            end
        end
        // Consume with in_valid still high: must not start a new op on that edge
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hs_no_b2b: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hs_idle: out_valid=%b want 0", out_valid);
        end
        // in_valid pulse during BUSY must be ignored
        @(negedge clk);
        opcode = 4'd3; operand1 = 8'd200; operand2 = 8'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        opcode = 4'd0; operand1 = 8'h01; operand2 = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (result !== 16'h041C || out_valid !== 1'b1) begin
            errors++; $display("FAIL hs_busy_pulse: result=%h ov=%b want 041C 1", result, out_valid);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hs_busy_extra: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        @(negedge clk);
        opcode = 4'd3; operand1 = 8'd200; operand2 = 8'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 16'h0000) begin
            errors++; $display("FAIL mid_rst_hold: ov=%b ir=%b result=%h want 0 0 0000", out_valid, in_ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 ||
            {flag_c, flag_z, flag_dz} !== 3'b000) begin
            errors++; $display("FAIL mid_rst_release: ir=%b ov=%b result=%h flags=%b want 1 0 0000 000",
                               in_ready, out_valid, result, {flag_c, flag_z, flag_dz});
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL mid_rst_no_valid: out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_mul16();
        int lat;
        @(negedge clk);
        opcode16 = 4'd2; operand1_16 = 16'hFFFF; operand2_16 = 16'hFFFF; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (out_valid16 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (result16 !== 32'hFFFE0001 || {flag_c16, flag_z16, flag_dz16} !== 3'b000) begin
            errors++; $display("FAIL mul16_result: got %h flags=%b want FFFE0001 000",
                               result16, {flag_c16, flag_z16, flag_dz16});
        end
        checks++;
        if (lat != MUL_LAT16) begin
            errors++; $display("FAIL mul16_latency: got %0d want %0d", lat, MUL_LAT16);
        end
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; opcode = 4'd0; operand1 = 8'h00; operand2 = 8'h00;
        in_valid16 = 1'b0; out_ready16 = 1'b0; opcode16 = 4'd0;
        operand1_16 = 16'h0000; operand2_16 = 16'h0000;
        test_reset();
        test_directed();
        test_handshake();
        test_random();
        test_reset_mid_div();
        test_mul16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
